// File: rtl/demm_tile_sequencer.sv
// DEMM tile sequencer: walks the (m, n, k) tile loop nest and emits A/B tile commands.
// Optional perf counters enabled by defining DEMM_SEQ_PERF_EN.
module demm_tile_sequencer #(
  parameter int TILE       = 16,
  parameter int ELEM_BYTES = 4,
  parameter int ADDR_W     = 64,
  parameter int CNT_W      = 24
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [31:0]       ctrl_reg,
  input  logic [31:0]       M_num,
  input  logic [31:0]       N_num,
  input  logic [31:0]       K_num,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_a_addr,
  output logic [ADDR_W-1:0] cmd_b_addr,
  output logic [31:0]       cmd_m_idx,
  output logic [31:0]       cmd_n_idx,
  output logic [31:0]       cmd_k_idx,
  output logic              cmd_first_k,
  output logic              cmd_last_k,
  output logic [31:0]       status_wire
`ifdef DEMM_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_DONE
  } state_t;

  localparam int TSH = $clog2(TILE);
  localparam int BSH = $clog2(TILE * ELEM_BYTES);
  localparam logic [ADDR_W-1:0] TSTEP = ADDR_W'(TILE * ELEM_BYTES);

  state_t state_q, state_d;
  logic              ctrl0_q, busy_q, done_q, err_q, abrt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       m_q, n_q, k_q;
  logic [31:0]       mt_q, nt_q, kt_q;
  logic [31:0]       mi_q, ni_q, ki_q;
  logic [ADDR_W-1:0] abase_q, bbase_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [ADDR_W-1:0] a_row_q, b_col_q;
  logic [ADDR_W-1:0] a_mstr_q, b_kstr_q;

  logic start, go, abort, hs, zero;
  logic k_last, n_last, m_last;
  logic [32:0] mt_w, nt_w, kt_w;
  logic unused_ok;

  assign start = ctrl_reg[0] & ~ctrl0_q;
  assign go    = start & ~ctrl_reg[1];
  assign abort = ctrl_reg[1] & busy_q;
  assign cmd_valid = (state_q == S_ISSUE);
  assign hs    = cmd_valid & cmd_ready;
  assign zero  = (m_q == '0) | (n_q == '0) | (k_q == '0);

  // Ceil-divide by the tile edge; one extra bit keeps M+TILE-1 from wrapping.
  assign mt_w = ({1'b0, m_q} + 33'(TILE - 1)) >> TSH;
  assign nt_w = ({1'b0, n_q} + 33'(TILE - 1)) >> TSH;
  assign kt_w = ({1'b0, k_q} + 33'(TILE - 1)) >> TSH;

  assign k_last = (ki_q == kt_q - 32'd1);
  assign n_last = (ni_q == nt_q - 32'd1);
  assign m_last = (mi_q == mt_q - 32'd1);

  assign unused_ok = ^{ctrl_reg[31:2], mt_w[32], nt_w[32], kt_w[32]};

  assign cmd_a_addr  = a_addr_q;
  assign cmd_b_addr  = b_addr_q;
  assign cmd_m_idx   = mi_q;
  assign cmd_n_idx   = ni_q;
  assign cmd_k_idx   = ki_q;
  assign cmd_first_k = cmd_valid & (ki_q == '0);
  assign cmd_last_k  = cmd_valid & k_last;

  always_comb begin
    status_wire = '0;
    status_wire[0] = busy_q;
    status_wire[1] = done_q;
    status_wire[2] = err_q;
    status_wire[3] = abrt_q;
    status_wire[8 +: CNT_W] = cnt_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_SETUP;
      S_SETUP: state_d = (abort || zero) ? S_IDLE : S_ISSUE;
      S_ISSUE: begin
        if (abort)
          state_d = S_IDLE;
        else if (hs && k_last && n_last && m_last)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ctrl0_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      abrt_q   <= 1'b0;
      cnt_q    <= '0;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      kt_q     <= '0;
      mi_q     <= '0;
      ni_q     <= '0;
      ki_q     <= '0;
      abase_q  <= '0;
      bbase_q  <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_row_q  <= '0;
      b_col_q  <= '0;
      a_mstr_q <= '0;
      b_kstr_q <= '0;
    end else begin
      ctrl0_q <= ctrl_reg[0];
      if (state_q == S_IDLE && go) begin
        m_q     <= M_num;
        n_q     <= N_num;
        k_q     <= K_num;
        abase_q <= a_base;
        bbase_q <= b_base;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        abrt_q  <= 1'b0;
        cnt_q   <= '0;
      end
      if (state_q == S_SETUP) begin
        mt_q     <= mt_w[31:0];
        nt_q     <= nt_w[31:0];
        kt_q     <= kt_w[31:0];
        a_mstr_q <= ADDR_W'(k_q) << BSH;
        b_kstr_q <= ADDR_W'(n_q) << BSH;
        mi_q     <= '0;
        ni_q     <= '0;
        ki_q     <= '0;
        a_addr_q <= abase_q;
        b_addr_q <= bbase_q;
        a_row_q  <= abase_q;
        b_col_q  <= bbase_q;
        if (abort) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          abrt_q <= 1'b1;
        end else if (zero) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
      end
      if (hs) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        if (!k_last) begin
          ki_q     <= ki_q + 32'd1;
          a_addr_q <= a_addr_q + TSTEP;
          b_addr_q <= b_addr_q + b_kstr_q;
        end else begin
          ki_q     <= '0;
          a_addr_q <= a_row_q;
          if (!n_last) begin
            ni_q     <= ni_q + 32'd1;
            b_col_q  <= b_col_q + TSTEP;
            b_addr_q <= b_col_q + TSTEP;
          end else begin
            ni_q     <= '0;
            b_col_q  <= bbase_q;
            b_addr_q <= bbase_q;
            if (!m_last) begin
              mi_q     <= mi_q + 32'd1;
              a_row_q  <= a_row_q + a_mstr_q;
              a_addr_q <= a_row_q + a_mstr_q;
            end
          end
        end
      end
      if (state_q == S_ISSUE) begin
        if (abort) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          abrt_q <= 1'b1;
        end else if (hs && k_last && n_last && m_last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

`ifdef DEMM_SEQ_PERF_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (state_q == S_IDLE && go) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy_q && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (cmd_valid && !cmd_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demm_tile_sequencer.sv
// Scoreboard bench for demm_tile_sequencer: directed runs, expected
// commands queued by the stimulus and checked by a negedge monitor.
module tb_demm_tile_sequencer;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] m;
    logic [31:0] n;
    logic [31:0] k;
    logic        f;
    logic        l;
  } cmd_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] ctrl_reg = '0;
  logic [31:0] M_num = '0, N_num = '0, K_num = '0;
  logic [63:0] a_base = '0, b_base = '0;
  logic        cmd_valid, cmd_ready;
  logic [63:0] cmd_a_addr, cmd_b_addr;
  logic [31:0] cmd_m_idx, cmd_n_idx, cmd_k_idx;
  logic        cmd_first_k, cmd_last_k;
  logic [31:0] status_wire;
`ifdef DEMM_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

  demm_tile_sequencer dut (
    .aclk        (aclk),
    .areset      (areset),
    .ctrl_reg    (ctrl_reg),
    .M_num       (M_num),
    .N_num       (N_num),
    .K_num       (K_num),
    .a_base      (a_base),
    .b_base      (b_base),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a_addr  (cmd_a_addr),
    .cmd_b_addr  (cmd_b_addr),
    .cmd_m_idx   (cmd_m_idx),
    .cmd_n_idx   (cmd_n_idx),
    .cmd_k_idx   (cmd_k_idx),
    .cmd_first_k (cmd_first_k),
    .cmd_last_k  (cmd_last_k),
    .status_wire (status_wire)
`ifdef DEMM_SEQ_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 aclk = ~aclk;

  int   n_cmp = 0;
  int   n_err = 0;
  cmd_t expq[$];
  bit   chk_en = 1'b1;
  bit   bp_mode = 1'b0;
  logic rdy_fixed = 1'b1;
  int   hs_cnt = 0;
  int   stall_cnt = 0;
  bit   valid_seen = 1'b0;
  logic [31:0] pat = 32'hB53C_96E1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic [63:0] a, input logic [63:0] b,
                               input int m, input int n, input int k,
                               input bit f, input bit l);
    cmd_t c;
    c.a = a; c.b = b; c.m = m; c.n = n; c.k = k; c.f = f; c.l = l;
    expq.push_back(c);
  endfunction

  // Ready driver: fixed level or a rotating pseudo-random pattern.
  always @(posedge aclk) begin
    #1;
    if (bp_mode) pat = {pat[30:0], pat[31]};
    cmd_ready = bp_mode ? pat[0] : rdy_fixed;
  end
  initial cmd_ready = 1'b1;

  // Monitor: pops expectations on handshakes, checks stability on stalls.
  cmd_t held;
  bit   stalled = 1'b0;
  always @(negedge aclk) begin
    cmd_t e;
    if (cmd_valid) valid_seen = 1'b1;
    if (stalled) begin
      chk("stall_valid", {63'd0, cmd_valid}, 64'd1);
      chk("stall_a", cmd_a_addr, held.a);
      chk("stall_b", cmd_b_addr, held.b);
      chk("stall_idx", {cmd_m_idx, cmd_k_idx}, {held.m, held.k});
      stalled = 1'b0;
    end
    if (cmd_valid && !cmd_ready) begin
      stall_cnt++;
      held.a = cmd_a_addr; held.b = cmd_b_addr;
      held.m = cmd_m_idx;  held.k = cmd_k_idx;
      stalled = 1'b1;
    end
    if (cmd_valid && cmd_ready) begin
      hs_cnt++;
      if (chk_en) begin
        if (expq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_cmd: a=%0h b=%0h", cmd_a_addr, cmd_b_addr);
        end else begin
          e = expq.pop_front();
          chk("cmd_a", cmd_a_addr, e.a);
          chk("cmd_b", cmd_b_addr, e.b);
          chk("cmd_mnk", {16'd0, cmd_m_idx[15:0], cmd_n_idx[15:0], cmd_k_idx[15:0]},
              {16'd0, e.m[15:0], e.n[15:0], e.k[15:0]});
          chk("cmd_fl", {62'd0, cmd_first_k, cmd_last_k}, {62'd0, e.f, e.l});
        end
      end
    end
  end

  task automatic setup(input int m, input int n, input int k,
                       input logic [63:0] a, input logic [63:0] b);
    M_num = m; N_num = n; K_num = k; a_base = a; b_base = b;
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1;
    ctrl_reg[0] = 1'b1;
    @(posedge aclk); #1;
    ctrl_reg[0] = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge aclk);
      if (status_wire[1]) begin ok = 1'b1; break; end
    end
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  task automatic push_loop_case();
    push(64'h0,   64'h0,   0, 0, 0, 1, 0);
    push(64'h40,  64'h400, 0, 0, 1, 0, 0);
    push(64'h80,  64'h800, 0, 0, 2, 0, 1);
    push(64'hC00, 64'h0,   1, 0, 0, 1, 0);
    push(64'hC40, 64'h400, 1, 0, 1, 0, 0);
    push(64'hC80, 64'h800, 1, 0, 2, 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_valid", {63'd0, cmd_valid}, 64'd0);
    chk("rst_status", {32'd0, status_wire}, 64'd0);
    chk("rst_addr", cmd_a_addr | cmd_b_addr, 64'd0);
    areset = 1'b0;

    // Single tile, start held high afterwards.
    setup(16, 16, 16, 64'h1000, 64'h8000);
    push(64'h1000, 64'h8000, 0, 0, 0, 1, 1);
    @(posedge aclk); #1;
    ctrl_reg[0] = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("t1_busy", {32'd0, status_wire}, 64'h1);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("t1_status", {32'd0, status_wire}, 64'h102);
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    chk("t1_no_retrig", {32'd0, status_wire}, 64'h102);
    ctrl_reg[0] = 1'b0;
    chk("t1_q_empty", expq.size(), 0);

    // Loop order, full throughput, exact cycle count.
    setup(32, 16, 48, 64'h0, 64'h0);
    push_loop_case();
    @(posedge aclk); #1;
    ctrl_reg[0] = 1'b1;
    repeat (7) @(posedge aclk);
    @(negedge aclk);
    chk("t2_not_done_yet", {63'd0, status_wire[1]}, 64'd0);
    @(posedge aclk);
    @(negedge aclk);
    chk("t2_status", {32'd0, status_wire}, 64'h602);
    ctrl_reg[0] = 1'b0;
    chk("t2_q_empty", expq.size(), 0);

    // Backpressure: same sequence under toggling ready.
    setup(32, 16, 48, 64'h0, 64'h0);
    push_loop_case();
    stall_cnt = 0;
    bp_mode = 1'b1;
    pulse_start();
    wait_done("t3_done");
    chk("t3_status", {32'd0, status_wire}, 64'h602);
    chk("t3_q_empty", expq.size(), 0);
`ifdef DEMM_SEQ_PERF_EN
    chk("t3_perf_stall", {32'd0, perf_stall_cycles}, stall_cnt);
`endif
    bp_mode = 1'b0;
    @(posedge aclk);

    // Zero dimension.
    setup(16, 16, 0, 64'h0, 64'h0);
    valid_seen = 1'b0;
    pulse_start();
    wait_done("t4_done");
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("t4_status", {32'd0, status_wire}, 64'h6);
    chk("t4_no_valid", {63'd0, valid_seen}, 64'd0);

    // Abort after the 5th handshake; the 6th lands with the abort.
    setup(64, 64, 64, 64'h0, 64'h0);
    push(64'h0,  64'h0,    0, 0, 0, 1, 0);
    push(64'h40, 64'h1000, 0, 0, 1, 0, 0);
    push(64'h80, 64'h2000, 0, 0, 2, 0, 0);
    push(64'hC0, 64'h3000, 0, 0, 3, 0, 1);
    push(64'h0,  64'h40,   0, 1, 0, 1, 0);
    push(64'h40, 64'h1040, 0, 1, 1, 0, 0);
    hs_cnt = 0;
    pulse_start();
    for (int i = 0; i < 100 && hs_cnt < 5; i++) @(posedge aclk);
    #1;
    ctrl_reg[1] = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("t5_valid_low", {63'd0, cmd_valid}, 64'd0);
    chk("t5_status", {32'd0, status_wire}, 64'h60A);
    chk("t5_q_empty", expq.size(), 0);
    @(posedge aclk); #1;
    ctrl_reg[1] = 1'b0;

    // Reset in the middle of a run.
    chk_en = 1'b0;
    hs_cnt = 0;
    pulse_start();
    for (int i = 0; i < 100 && hs_cnt < 3; i++) @(posedge aclk);
    #1;
    areset = 1'b1;
    #1;
    chk("t6_valid", {63'd0, cmd_valid}, 64'd0);
    chk("t6_status", {32'd0, status_wire}, 64'd0);
    chk("t6_addr", cmd_a_addr | cmd_b_addr, 64'd0);
    chk("t6_idx", {32'd0, cmd_m_idx | cmd_n_idx | cmd_k_idx}, 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    valid_seen = 1'b0;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    chk("t6_no_cmd", {63'd0, valid_seen}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
